sparse_encoder: RTL and testbench

- Run-length encoder for the sparse MAC path. It converts a dense element stream, one value per beat, into (skip, value) entries.
- skip is the number of zeros before the value. Zero elements produce no entry, except for run saturation and end-of-vector.
- It sits on the write side of the operand SRAM and produces entries in the format the decoder expands back into (index, value).
- Decoding its output (index accumulates skip+1 from -1) must reproduce the original vector exactly, including its length.

---
 rtl/sparse_encoder.sv | 116 +++++++++++
 tb/tb_sparse_encoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_encoder.sv
// Run-length encoder for the sparse MAC write path.
// Turns a dense element stream into (skip, value, last) entries. skip counts
// the zeros in front of the value. A saturated run emits a zero-valued
// padding entry, and the last beat always emits an entry, so the decoder can
// rebuild both the contents and the length of the vector.
module sparse_encoder #(
    parameter int VALUE_W = 8,
    parameter int SKIP_W  = 4
) (
    input  logic               mac_clk,
    input  logic               mac_rst,
    input  logic               dense_valid_i,
    output logic               dense_ready_o,
    input  logic [VALUE_W-1:0] dense_value_i,
    input  logic               dense_last_i,
    output logic               enc_valid_o,
    input  logic               enc_ready_i,
    output logic [SKIP_W-1:0]  enc_skip_o,
    output logic [VALUE_W-1:0] enc_value_o,
    output logic               enc_last_o
);

    localparam logic [SKIP_W-1:0] SKIP_MAX = '1;
    localparam logic [SKIP_W-1:0] RUN_ONE  = SKIP_W'(1);

    // The head entry lives directly in the enc_* output registers.
    // The second slot holds the entry queued behind the head.
    logic               active;
    logic [1:0]         count;
    logic [SKIP_W-1:0]  run;
    logic [SKIP_W-1:0]  run_next;
    logic [SKIP_W-1:0]  q1_skip;
    logic [VALUE_W-1:0] q1_value;
    logic               q1_last;
    logic               accept;
    logic               pop;
    logic               push;

    // Ready comes only from registers. active keeps ready low during reset
    // even though count is already zero then.
    assign dense_ready_o = active & (count != 2'd2);
    assign enc_valid_o   = (count != 2'd0);
    assign accept        = dense_valid_i & dense_ready_o;
    assign pop           = enc_valid_o & enc_ready_i;

    // Decide per accepted beat whether an entry is produced and where the run goes.
    // In every push case the new entry is (run, dense_value_i, dense_last_i).
    // For padding, value is zero, run is SKIP_MAX and last is clear.
    always_comb begin
        push     = 1'b0;
        run_next = run;
        if (accept) begin
            if (dense_last_i || (dense_value_i != '0) || (run == SKIP_MAX)) begin
                push     = 1'b1;
                run_next = '0;
            end else begin
                run_next = run + RUN_ONE;
            end
        end
    end

    // Run counter, two-entry output queue and ready enable.
    always_ff @(posedge mac_clk or posedge mac_rst) begin
        if (mac_rst) begin
            active      <= 1'b0;
            count       <= 2'd0;
            run         <= '0;
            enc_skip_o  <= '0;
            enc_value_o <= '0;
            enc_last_o  <= 1'b0;
            q1_skip     <= '0;
            q1_value    <= '0;
            q1_last     <= 1'b0;
        end else begin
            active <= 1'b1;
            run    <= run_next;
            case ({push, pop})
                2'b10: begin
                    count <= count + 2'd1;
                    if (count == 2'd0) begin
                        enc_skip_o  <= run;
                        enc_value_o <= dense_value_i;
                        enc_last_o  <= dense_last_i;
                    end else begin
                        q1_skip  <= run;
                        q1_value <= dense_value_i;
                        q1_last  <= dense_last_i;
                    end
                end
                2'b01: begin
                    count       <= count - 2'd1;
                    enc_skip_o  <= q1_skip;
                    enc_value_o <= q1_value;
                    enc_last_o  <= q1_last;
                end
                2'b11: begin
                    // Push and pop together keep the count unchanged.
                    if (count == 2'd1) begin
                        enc_skip_o  <= run;
                        enc_value_o <= dense_value_i;
                        enc_last_o  <= dense_last_i;
                    end else begin
                        enc_skip_o  <= q1_skip;
                        enc_value_o <= q1_value;
                        enc_last_o  <= q1_last;
                        q1_skip     <= run;
                        q1_value    <= dense_value_i;
                        q1_last     <= dense_last_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sparse_encoder.sv
// Testbench for sparse_encoder.
// Each scenario pushes its expected entries into a scoreboard queue. A monitor
// pops and compares one entry every time an output beat transfers.
module tb_sparse_encoder;

    logic       mac_clk = 1'b0;
    logic       mac_rst = 1'b1;
    logic       dense_valid_i = 1'b0;
    logic       dense_ready_o;
    logic [7:0] dense_value_i = '0;
    logic       dense_last_i = 1'b0;
    logic       enc_valid_o;
    logic       enc_ready_i = 1'b1;
    logic [3:0] enc_skip_o;
    logic [7:0] enc_value_o;
    logic       enc_last_o;

    int n_checks = 0;
    int n_fail   = 0;
    int out_beats = 0;
    logic [12:0] exp_q[$];

    sparse_encoder #(.VALUE_W(8), .SKIP_W(4)) dut (
        .mac_clk       (mac_clk),
        .mac_rst       (mac_rst),
        .dense_valid_i (dense_valid_i),
        .dense_ready_o (dense_ready_o),
        .dense_value_i (dense_value_i),
        .dense_last_i  (dense_last_i),
        .enc_valid_o   (enc_valid_o),
        .enc_ready_i   (enc_ready_i),
        .enc_skip_o    (enc_skip_o),
        .enc_value_o   (enc_value_o),
        .enc_last_o    (enc_last_o)
    );

    always #5 mac_clk = ~mac_clk;

    // Scoreboard: a transfer happens at the next rising edge when valid & ready.
    always @(negedge mac_clk) begin
        logic [12:0] e;
        if (!mac_rst && enc_valid_o && enc_ready_i) begin
            out_beats++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_entry got (%0d,%0d,%0d) expected none",
                         enc_skip_o, enc_value_o, enc_last_o);
            end else begin
                e = exp_q.pop_front();
                if ({enc_skip_o, enc_value_o, enc_last_o} !== e) begin
                    n_fail++;
                    $display("FAIL entry got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                             enc_skip_o, enc_value_o, enc_last_o, e[12:9], e[8:1], e[0]);
                end
            end
        end
    end

    task automatic push_exp(input logic [3:0] s, input logic [7:0] v, input logic l);
        exp_q.push_back({s, v, l});
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic drive(input logic [7:0] v, input logic l);
        int guard = 0;
        dense_valid_i = 1'b1;
        dense_value_i = v;
        dense_last_i  = l;
        while (!dense_ready_o && guard < 50) begin
            @(posedge mac_clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL drive_timeout ready=%0d expected 1", dense_ready_o);
        end
        @(posedge mac_clk); #1;
        dense_valid_i = 1'b0;
        dense_value_i = '0;
        dense_last_i  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int guard = 0;
        while ((exp_q.size() != 0 || enc_valid_o) && guard < 100) begin
            @(posedge mac_clk); #1;
            guard++;
        end
        n_checks++;
        if (guard >= 100) begin
            n_fail++;
            $display("FAIL %s_drain pending=%0d valid=%0d expected 0 and 0",
                     name, exp_q.size(), enc_valid_o);
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({dense_ready_o, enc_valid_o, enc_skip_o, enc_value_o, enc_last_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got rdy=%0d v=%0d (%0d,%0d,%0d) expected all 0",
                     dense_ready_o, enc_valid_o, enc_skip_o, enc_value_o, enc_last_o);
        end
        @(posedge mac_clk); #1;
        mac_rst = 1'b0;
        @(posedge mac_clk); #1;
        n_checks++;
        if (dense_ready_o !== 1'b1 || enc_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release got rdy=%0d v=%0d expected rdy=1 v=0",
                     dense_ready_o, enc_valid_o);
        end
    endtask

    task automatic test_basic();
        int start = out_beats;
        push_exp(4'd3, 8'd5, 1'b0);
        push_exp(4'd6, 8'd4, 1'b1);
        repeat (3) drive(8'd0, 1'b0);
        n_checks++;
        if (enc_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_no_entry_for_zeros got valid=%0d expected 0", enc_valid_o);
        end
        drive(8'd5, 1'b0);
        n_checks++;
        if ({enc_valid_o, enc_skip_o, enc_value_o, enc_last_o} !== {1'b1, 4'd3, 8'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_latency got v=%0d (%0d,%0d,%0d) expected v=1 (3,5,0)",
                     enc_valid_o, enc_skip_o, enc_value_o, enc_last_o);
        end
        repeat (6) drive(8'd0, 1'b0);
        drive(8'd4, 1'b1);
        wait_drain("basic");
        n_checks++;
        if (out_beats - start !== 2) begin
            n_fail++;
            $display("FAIL basic_beat_count got %0d expected 2", out_beats - start);
        end
    endtask

    task automatic test_saturation();
        push_exp(4'd15, 8'd0, 1'b0);
        push_exp(4'd4, 8'd7, 1'b1);
        repeat (20) drive(8'd0, 1'b0);
        drive(8'd7, 1'b1);
        wait_drain("saturation");
    endtask

    task automatic test_trailing();
        push_exp(4'd0, 8'd9, 1'b0);
        push_exp(4'd1, 8'd0, 1'b1);
        drive(8'd9, 1'b0);
        drive(8'd0, 1'b0);
        drive(8'd0, 1'b1);
        wait_drain("trailing");
        push_exp(4'd0, 8'd0, 1'b1);
        drive(8'd0, 1'b1);
        wait_drain("single_zero");
        push_exp(4'd0, 8'd255, 1'b0);
        push_exp(4'd2, 8'd128, 1'b1);
        drive(8'd255, 1'b0);
        drive(8'd0, 1'b0);
        drive(8'd0, 1'b0);
        drive(8'd128, 1'b1);
        wait_drain("passthrough");
    endtask

    task automatic test_backpressure();
        push_exp(4'd0, 8'd1, 1'b0);
        push_exp(4'd0, 8'd2, 1'b0);
        push_exp(4'd0, 8'd3, 1'b0);
        push_exp(4'd0, 8'd4, 1'b1);
        enc_ready_i = 1'b0;
        drive(8'd1, 1'b0);
        drive(8'd2, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({dense_ready_o, enc_valid_o, enc_skip_o, enc_value_o, enc_last_o}
                !== {1'b0, 1'b1, 4'd0, 8'd1, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold cyc%0d got rdy=%0d v=%0d (%0d,%0d,%0d) expected rdy=0 v=1 (0,1,0)",
                         i, dense_ready_o, enc_valid_o, enc_skip_o, enc_value_o, enc_last_o);
            end
            @(posedge mac_clk); #1;
        end
        enc_ready_i = 1'b1;
        drive(8'd3, 1'b0);
        drive(8'd4, 1'b1);
        wait_drain("backpressure");
        // Sustained throughput: with the sink ready, every beat is taken.
        push_exp(4'd0, 8'd10, 1'b0);
        push_exp(4'd0, 8'd11, 1'b0);
        push_exp(4'd0, 8'd12, 1'b1);
        drive(8'd10, 1'b0);
        drive(8'd11, 1'b0);
        n_checks++;
        if (dense_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL throughput_ready got %0d expected 1", dense_ready_o);
        end
        drive(8'd12, 1'b1);
        wait_drain("throughput");
    endtask

    task automatic test_back_to_back();
        push_exp(4'd1, 8'd6, 1'b1);
        push_exp(4'd0, 8'd8, 1'b1);
        drive(8'd0, 1'b0);
        drive(8'd6, 1'b1);
        drive(8'd8, 1'b1);
        wait_drain("back_to_back");
    endtask

    task automatic test_reset_mid();
        enc_ready_i = 1'b0;
        drive(8'd3, 1'b0);
        repeat (3) drive(8'd0, 1'b0);
        mac_rst = 1'b1;
        #1;
        n_checks++;
        if ({dense_ready_o, enc_valid_o, enc_skip_o, enc_value_o, enc_last_o} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs got rdy=%0d v=%0d (%0d,%0d,%0d) expected all 0",
                     dense_ready_o, enc_valid_o, enc_skip_o, enc_value_o, enc_last_o);
        end
        @(posedge mac_clk); #1;
        mac_rst = 1'b0;
        enc_ready_i = 1'b1;
        @(posedge mac_clk); #1;
        push_exp(4'd0, 8'd5, 1'b1);
        drive(8'd5, 1'b1);
        wait_drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_trailing();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover got %0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
